// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM state encoding and
// the data / byte-enable widths used by the controller and its RAM.
package mem_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/mem_ram_be.sv
// Synchronous single-port word RAM with per-byte write enables and a
// registered (read-before-write) read port.
module mem_ram_be
  import mem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [BE_W-1:0]   i_be,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (i_we && i_be[i]) begin
        r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_resp_ctrl.sv
// Memory-side responder: accepts one request at a time, inserts a fixed
// number of wait states, then performs a byte-enabled word access and responds.
module mem_resp_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam logic [7:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 8'd0 : 8'(WAIT_CYCLES - 1);

  state_t            r_state;
  state_t            w_nextState;
  logic [7:0]        r_waitCnt;
  logic              r_write;
  logic [31:0]       r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_be;
  logic [DATA_W-1:0] r_rspRdata;
  logic              r_rspErr;

  logic              w_accept;
  logic              w_rspFire;
  logic              w_err;
  logic              w_ramWe;
  logic [ADDR_W-1:0] w_ramAddr;
  logic [DATA_W-1:0] w_ramRdata;

  assign w_accept  = (r_state == IDLE) && req_valid;
  assign w_rspFire = (r_state == RESP) && rsp_ready;
  assign w_err     = (r_addr[1:0] != 2'b00) || (r_addr[31:ADDR_W+2] != '0);

  // Reset gates the write so an ACCESS edge coinciding with reset never commits
  assign w_ramWe   = (r_state == ACCESS) && r_write && !w_err && !rst;
  // The RAM reads at the accepting edge too, so data is ready even with zero wait states
  assign w_ramAddr = (r_state == IDLE) ? req_addr[ADDR_W+1:2] : r_addr[ADDR_W+1:2];

  mem_ram_be #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .i_we    (w_ramWe),
    .i_be    (r_be),
    .i_addr  (w_ramAddr),
    .i_wdata (r_wdata),
    .o_rdata (w_ramRdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_nextState = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        if (r_waitCnt == 8'd0) begin
          w_nextState = ACCESS;
        end
      end
      ACCESS: begin
        w_nextState = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_waitCnt <= 8'd0;
    end else if (w_accept) begin
      r_waitCnt <= WAIT_INIT;
    end else if ((r_state == WAIT) && (r_waitCnt != 8'd0)) begin
      r_waitCnt <= r_waitCnt - 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else if (w_accept) begin
      r_write <= req_write;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_be    <= req_be;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rspRdata <= '0;
      r_rspErr   <= 1'b0;
    end else if (r_state == ACCESS) begin
      r_rspErr   <= w_err;
      r_rspRdata <= (w_err || r_write) ? '0 : w_ramRdata;
    end else if (w_rspFire) begin
      r_rspRdata <= '0;
      r_rspErr   <= 1'b0;
    end
  end

  assign rsp_rdata = r_rspRdata;
  assign rsp_err   = r_rspErr;

endmodule

// File: tb/tb_mem_resp_ctrl.sv
// Self-checking bench for mem_resp_ctrl: a WAIT_CYCLES=2 instance (index 0)
// and a WAIT_CYCLES=0 instance (index 1), checked against a scoreboard.
module tb_mem_resp_ctrl;

  localparam int ADDR_W = 10;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [1:0]  reqValid;
  logic [1:0]  reqReady;
  logic [1:0]  reqWrite;
  logic [31:0] reqAddr  [2];
  logic [31:0] reqWdata [2];
  logic [3:0]  reqBe    [2];
  logic [1:0]  rspValid;
  logic [1:0]  rspReady;
  logic [31:0] rspRdata [2];
  logic [1:0]  rspErr;

  int          checks;
  int          failures;
  exp_t        sbq [$];
  logic [31:0] model [int];

  mem_resp_ctrl #(.ADDR_W(ADDR_W), .WAIT_CYCLES(2)) dutWait2 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (reqValid[0]),
    .req_ready (reqReady[0]),
    .req_write (reqWrite[0]),
    .req_addr  (reqAddr[0]),
    .req_wdata (reqWdata[0]),
    .req_be    (reqBe[0]),
    .rsp_valid (rspValid[0]),
    .rsp_ready (rspReady[0]),
    .rsp_rdata (rspRdata[0]),
    .rsp_err   (rspErr[0])
  );

  mem_resp_ctrl #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) dutWait0 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (reqValid[1]),
    .req_ready (reqReady[1]),
    .req_write (reqWrite[1]),
    .req_addr  (reqAddr[1]),
    .req_wdata (reqWdata[1]),
    .req_be    (reqBe[1]),
    .rsp_valid (rspValid[1]),
    .rsp_ready (rspReady[1]),
    .rsp_rdata (rspRdata[1]),
    .rsp_err   (rspErr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input int d, input string tag);
    chk({tag, "_req_ready"}, 32'(reqReady[d]), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rspValid[d]), 32'd0);
    chk({tag, "_rsp_rdata"}, rspRdata[d], 32'd0);
    chk({tag, "_rsp_err"}, 32'(rspErr[d]), 32'd0);
  endtask

  // One complete transaction: predict, drive, track latency, stall, handshake
  task automatic runTxn(input int d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input int stall, input bit holdValid, input string tag);
    exp_t        e;
    int          edges;
    int          key;
    int          waitCycles;
    logic [31:0] word;
    waitCycles = (d == 0) ? 2 : 0;
    key        = d * (1 << ADDR_W) + int'(addr[ADDR_W+1:2]);
    e.err      = (addr[1:0] != 2'b00) || (addr[31:ADDR_W+2] != '0);
    e.rdata    = 32'd0;
    if (!e.err) begin
      if (wr) begin
        word = model.exists(key) ? model[key] : 32'd0;
        for (int i = 0; i < 4; i++) begin
          if (be[i]) word[8*i +: 8] = wdata[8*i +: 8];
        end
        model[key] = word;
      end else begin
        e.rdata = model[key];
      end
    end
    sbq.push_back(e);

    chk({tag, "_accept_ready"}, 32'(reqReady[d]), 32'd1);
    reqValid[d] = 1'b1;
    reqWrite[d] = wr;
    reqAddr[d]  = addr;
    reqWdata[d] = wdata;
    reqBe[d]    = be;
    rspReady[d] = (stall == 0);
    @(posedge clk);
    @(negedge clk);
    if (holdValid) begin
      reqWrite[d] = ~wr;
      reqAddr[d]  = addr ^ 32'h4;
      reqWdata[d] = ~wdata;
      reqBe[d]    = ~be;
    end else begin
      reqValid[d] = 1'b0;
    end

    edges = 1;
    while (!rspValid[d] && edges < 40) begin
      chk({tag, "_busy_ready"}, 32'(reqReady[d]), 32'd0);
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    chk({tag, "_latency"}, 32'(edges), 32'(waitCycles + 2));
    chk({tag, "_rsp_valid"}, 32'(rspValid[d]), 32'd1);

    e = sbq.pop_front();
    for (int k = 0; k < stall; k++) begin
      chk({tag, "_stall_valid"}, 32'(rspValid[d]), 32'd1);
      chk({tag, "_stall_rdata"}, rspRdata[d], e.rdata);
      chk({tag, "_stall_ready"}, 32'(reqReady[d]), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    rspReady[d] = 1'b1;
    reqValid[d] = 1'b0;
    chk({tag, "_rdata"}, rspRdata[d], e.rdata);
    chk({tag, "_err"}, 32'(rspErr[d]), 32'(e.err));
    @(posedge clk);
    @(negedge clk);
    checkIdle(d, {tag, "_after"});
  endtask

  task automatic applyStimulus();
    // Write then read back, with byte enables ignored on the read
    runTxn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, "wr10_full");
    runTxn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, "rd10_full");
    runTxn(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, 0, 1'b0, "wr10_byte0");
    runTxn(0, 1'b0, 32'h10, 32'h0, 4'hF, 0, 1'b0, "rd10_partial");
    runTxn(0, 1'b1, 32'h10, 32'h55555555, 4'b0000, 0, 1'b0, "wr10_be0");
    runTxn(0, 1'b0, 32'h10, 32'h0, 4'hF, 0, 1'b0, "rd10_after_be0");
    // Faulting accesses
    runTxn(0, 1'b0, 32'h12, 32'h0, 4'hF, 0, 1'b0, "rd12_misalign");
    runTxn(0, 1'b0, 32'h00001000, 32'h0, 4'hF, 0, 1'b0, "rd1000_range");
    runTxn(0, 1'b1, 32'h13, 32'hFFFFFFFF, 4'hF, 0, 1'b0, "wr13_misalign");
    runTxn(0, 1'b0, 32'h10, 32'h0, 4'hF, 0, 1'b0, "rd10_after_fault");
    // Response backpressure, then the top valid word
    runTxn(0, 1'b0, 32'h10, 32'h0, 4'hF, 5, 1'b0, "rd10_stall5");
    runTxn(0, 1'b1, 32'hFFC, 32'hCAFEF00D, 4'hF, 0, 1'b0, "wr_top");
    runTxn(0, 1'b0, 32'hFFC, 32'h0, 4'hF, 0, 1'b0, "rd_top");
    // Zero wait states, request held and altered while busy
    runTxn(1, 1'b1, 32'h0, 32'h12345678, 4'hF, 0, 1'b1, "w0_wr0_hold");
    runTxn(1, 1'b0, 32'h0, 32'h0, 4'hF, 0, 1'b1, "w0_rd0_hold");
    checkIdle(1, "w0_no_second");

    // Abort a write with reset during its wait states
    runTxn(0, 1'b1, 32'h20, 32'h11111111, 4'hF, 0, 1'b0, "wr20_init");
    chk("abort_accept_ready", 32'(reqReady[0]), 32'd1);
    reqValid[0] = 1'b1;
    reqWrite[0] = 1'b1;
    reqAddr[0]  = 32'h20;
    reqWdata[0] = 32'h22222222;
    reqBe[0]    = 4'hF;
    rspReady[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reqValid[0] = 1'b0;
    chk("abort_in_wait", 32'(reqReady[0]), 32'd0);
    rst = 1'b1;
    #1;
    checkIdle(0, "abort_rst");
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_rsp_in_rst", 32'(rspValid[0]), 32'd0);
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_rsp_after", 32'(rspValid[0]), 32'd0);
    end
    runTxn(0, 1'b0, 32'h20, 32'h0, 4'hF, 0, 1'b0, "rd20_after_abort");
  endtask

  task automatic checkOutput();
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    reqValid = 2'b00;
    reqWrite = 2'b00;
    rspReady = 2'b00;
    for (int d = 0; d < 2; d++) begin
      reqAddr[d]  = 32'd0;
      reqWdata[d] = 32'd0;
      reqBe[d]    = 4'd0;
    end
    $display("[TB] reset");
    repeat (2) @(negedge clk);
    checkIdle(0, "reset_w2");
    checkIdle(1, "reset_w0");
    rst = 1'b0;
    @(negedge clk);
    checkIdle(0, "post_reset_w2");

    $display("[TB] directed transactions");
    applyStimulus();
    checkOutput();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
